board_cursor_ctrl: RTL

//  Input-side producer for the display pipeline: turns debounced button levels into pointer

---
 rtl/board_cursor_ctrl_pkg.sv | 31 +++
 rtl/board_cursor_ctrl_key_edge_arb.sv | 42 ++++
 rtl/board_cursor_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/board_cursor_ctrl_pkg.sv
// Shared constants and types for the board cursor controller.
// Board geometry, bus widths, cell codes, command encodings and FSM states.
package board_cursor_ctrl_pkg;

    localparam int BOARD_W_DEF         = 15;
    localparam int BOARD_H_DEF         = 15;
    localparam int BOARD_WIDTH_BITS    = 4;
    localparam int BOARD_HEIGHT_BITS   = 4;
    localparam int WINNING_STATUS_BITS = 2;
    localparam int BOARD_SIZE          = 2 * BOARD_W_DEF * BOARD_H_DEF;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_PLACE = 3'd1,
        CMD_UP    = 3'd2,
        CMD_DOWN  = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_NOTIFY = 2'd2
    } state_e;

endpackage

// File: rtl/board_cursor_ctrl_key_edge_arb.sv
// Key edge detector and arbiter.
// Registers the button levels, detects rising edges and keeps a single
// command per cycle (place > up > down > left > right).
// Ports: clk, reset (sync, active-high), key_* levels in; cmd_valid/cmd out
// (combinational, valid in the cycle the rise is seen).
module board_cursor_ctrl_key_edge_arb
    import board_cursor_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    input  logic key_place,
    output logic cmd_valid,
    output cmd_e cmd
);

    logic [4:0] keys;
    logic [4:0] key_q;
    logic [4:0] rise;

    assign keys = {key_place, key_up, key_down, key_left, key_right};
    assign rise = keys & ~key_q;

    always_ff @(posedge clk) begin
        if (reset) key_q <= '0;
        else       key_q <= keys;
    end

    always_comb begin
        cmd = CMD_NONE;
        if      (rise[4]) cmd = CMD_PLACE;
        else if (rise[3]) cmd = CMD_UP;
        else if (rise[2]) cmd = CMD_DOWN;
        else if (rise[1]) cmd = CMD_LEFT;
        else if (rise[0]) cmd = CMD_RIGHT;
        cmd_valid = |rise;
    end

endmodule

// File: rtl/board_cursor_ctrl.sv
// Board cursor controller: turns button rises into pointer moves and stone
// placements, owns board/pointer/player registers read by the renderer.
// Ports: Clck, Reset (sync, active-high), key_* buttons, gaming_status
// (0 = running), paint_busy (repaint in flight); board, pointer_loc_x/y,
// current_player, working (1-cycle repaint request), illegal (1-cycle reject).
module board_cursor_ctrl
    import board_cursor_ctrl_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic                           Clck,
    input  logic                           Reset,
    input  logic                           key_up,
    input  logic                           key_down,
    input  logic                           key_left,
    input  logic                           key_right,
    input  logic                           key_place,
    input  logic [WINNING_STATUS_BITS-1:0] gaming_status,
    input  logic                           paint_busy,
    output logic [BOARD_SIZE-1:0]          board,
    output logic [BOARD_WIDTH_BITS-1:0]    pointer_loc_x,
    output logic [BOARD_HEIGHT_BITS-1:0]   pointer_loc_y,
    output logic                           current_player,
    output logic                           working,
    output logic                           illegal
);

    localparam int BW    = BOARD_WIDTH_BITS;
    localparam int BH    = BOARD_HEIGHT_BITS;
    localparam int IDX_W = $clog2(BOARD_W * BOARD_H);

    localparam logic [BW-1:0] X_MAX = BW'(BOARD_W - 1);
    localparam logic [BH-1:0] Y_MAX = BH'(BOARD_H - 1);
    localparam logic [BW-1:0] X_ONE = BW'(1);
    localparam logic [BH-1:0] Y_ONE = BH'(1);

    state_e            state, state_nxt;
    logic              pend_valid;
    cmd_e              pend_cmd;
    logic              cmd_valid;
    cmd_e              cmd;
    logic [IDX_W-1:0]  cur_idx;
    logic [1:0]        cur_cell;
    logic [BW-1:0]     nxt_x;
    logic [BH-1:0]     nxt_y;
    logic              place_ok, place_bad;

    board_cursor_ctrl_key_edge_arb u_arb (
        .clk       (Clck),
        .reset     (Reset),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_place (key_place),
        .cmd_valid (cmd_valid),
        .cmd       (cmd)
    );

    assign cur_idx  = IDX_W'(pointer_loc_y) * IDX_W'(BOARD_W) + IDX_W'(pointer_loc_x);
    assign cur_cell = board[{cur_idx, 1'b0} +: 2];
    assign working  = (state == ST_NOTIFY);

    always_comb begin
        state_nxt = state;
        nxt_x     = pointer_loc_x;
        nxt_y     = pointer_loc_y;
        place_ok  = 1'b0;
        place_bad = 1'b0;
        case (state)
            ST_IDLE: if (pend_valid && !paint_busy) state_nxt = ST_APPLY;
            ST_APPLY: begin
                case (pend_cmd)
                    CMD_PLACE: begin
                        if (cur_cell == CELL_EMPTY && gaming_status == '0) place_ok  = 1'b1;
                        else                                              place_bad = 1'b1;
                    end
                    CMD_UP:    nxt_y = (pointer_loc_y == '0)    ? Y_MAX : pointer_loc_y - Y_ONE;
                    CMD_DOWN:  nxt_y = (pointer_loc_y == Y_MAX) ? '0    : pointer_loc_y + Y_ONE;
                    CMD_LEFT:  nxt_x = (pointer_loc_x == '0)    ? X_MAX : pointer_loc_x - X_ONE;
                    CMD_RIGHT: nxt_x = (pointer_loc_x == X_MAX) ? '0    : pointer_loc_x + X_ONE;
                    default: ;
                endcase
                // A rejected placement is not a visible change: no repaint.
                state_nxt = (place_bad || pend_cmd == CMD_NONE) ? ST_IDLE : ST_NOTIFY;
            end
            ST_NOTIFY: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            state          <= ST_IDLE;
            pend_valid     <= 1'b0;
            pend_cmd       <= CMD_NONE;
            board          <= '0;
            pointer_loc_x  <= BW'(BOARD_W / 2);
            pointer_loc_y  <= BH'(BOARD_H / 2);
            current_player <= 1'b0;
            illegal        <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= place_bad;
            // The slot is being drained in APPLY, so a rise then may refill it.
            if (cmd_valid && (!pend_valid || state == ST_APPLY)) begin
                pend_valid <= 1'b1;
                pend_cmd   <= cmd;
            end else if (state == ST_APPLY) begin
                pend_valid <= 1'b0;
            end
            // nxt_x/nxt_y hold the current pointer outside APPLY.
            pointer_loc_x <= nxt_x;
            pointer_loc_y <= nxt_y;
            if (place_ok) begin
                board[{cur_idx, 1'b0} +: 2] <= current_player ? CELL_WHITE : CELL_BLACK;
                current_player              <= ~current_player;
            end
        end
    end

endmodule
